twos_to_signmag48_seq: RTL and testbench

//  Converts a 48-bit two's-complement value into sign + 48-bit unsigned magnitude. This is
//  the inverse-direction companion of the 16/32/48-bit negators. It uses one 16-bit
//  add-with-carry slice, time-multiplexed over three words, LSW first. The carry ripples

---
 rtl/twos_to_signmag48_seq_pkg.sv | 14 +
 rtl/twos_to_signmag48_seq_if.sv | 23 ++
 rtl/twos_to_signmag48_seq_slice.sv | 12 +
 rtl/twos_to_signmag48_seq.sv | 90 +++++++++
 tb/tb_twos_to_signmag48_seq.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/twos_to_signmag48_seq_pkg.sv
// Shared definitions for the sequential two's-complement to sign/magnitude converter.
// Word-slice geometry and FSM state encoding.
package sm_defs;
    localparam int WORD_W = 16;
    localparam int NWORDS = 3;
    localparam int DATA_W = WORD_W * NWORDS;
    localparam int IDX_W  = $clog2(NWORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/twos_to_signmag48_seq_if.sv
// Valid/ready bundle for the converter: operand in, sign/magnitude out.
// master drives operands and consumes results, slave is the converter.
interface twos_to_signmag48_seq_if;
    import sm_defs::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [DATA_W-1:0] out_mag;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag
    );
endinterface

// File: rtl/twos_to_signmag48_seq_slice.sv
// One word of the shared add-with-carry slice: {cout, sum} = a + cin.
// Kept combinational so it maps onto a single DSP adder half.
module signmag_word_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + (W+1)'(cin);
endmodule

// File: rtl/twos_to_signmag48_seq.sv
// 48-bit two's-complement to sign + magnitude, one 16-bit word per cycle, LSW first.
// Carry between words is held in a register; result registers update only on entry to DONE.
module twos_to_signmag48_seq
    import sm_defs::*;
(
    input logic                    clk,
    input logic                    rst_n,
    twos_to_signmag48_seq_if.slave bus
);
    localparam int ACC_W = (NWORDS - 1) * WORD_W;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] op_q;
    logic [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]  idx_q;
    logic              carry_q;
    logic              sign_q;
    logic              out_sign_q;
    logic [DATA_W-1:0] out_mag_q;

    logic [WORD_W-1:0] sum;
    logic              cout;
    logic              accept;
    logic              last;
    logic              in_neg;

    assign in_neg = bus.in_data[DATA_W-1];
    assign last   = (idx_q == IDX_W'(NWORDS - 1));
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = (state_q == IDLE) ||
                           ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sign  = out_sign_q;
    assign bus.out_mag   = out_mag_q;

    signmag_word_slice #(.W(WORD_W)) u_slice (
        .a    (op_q[WORD_W-1:0]),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CONV;
            CONV: if (last) state_d = DONE;
            DONE: begin
                if (bus.out_ready)
                    state_d = bus.in_valid ? CONV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // op shifts down so the slice always sees the current word in the low bits;
    // finished words shift into acc from the top so word 0 lands at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            sign_q     <= 1'b0;
            out_sign_q <= 1'b0;
            out_mag_q  <= '0;
        end else if (accept) begin
            sign_q  <= in_neg;
            op_q    <= in_neg ? ~bus.in_data : bus.in_data;
            carry_q <= in_neg;
            idx_q   <= '0;
        end else if (state_q == CONV) begin
            op_q    <= op_q >> WORD_W;
            acc_q   <= {sum, acc_q[ACC_W-1:WORD_W]};
            carry_q <= cout;
            idx_q   <= idx_q + IDX_W'(1);
            if (last) begin
                out_mag_q  <= {sum, acc_q};
                out_sign_q <= sign_q;
            end
        end
    end
endmodule

// File: tb/tb_twos_to_signmag48_seq.sv
// Self-checking bench for twos_to_signmag48_seq: directed corner cases plus random
// operands against an integer-arithmetic reference model.
module tb_twos_to_signmag48_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    twos_to_signmag48_seq_if bus ();

    twos_to_signmag48_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: interpret the 48-bit pattern as a signed integer, take |v|.
    function automatic logic [48:0] model(input logic [47:0] x);
        longint v;
        longint m;
        v = longint'(x);
        if (x >= 48'h8000_0000_0000) v = v - (longint'(1) <<< 48);
        m = (v < 0) ? -v : v;
        return {v < 0, m[47:0]};
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid, returning cycles since the accept edge (bounded).
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            step();
            lat++;
            if (lat == 1) chk({tag, "_busy_rdy"}, 64'(bus.in_ready), 64'd0);
        end
    endtask

    task automatic run(input string tag, input logic [47:0] x);
        logic [48:0] e;
        int lat;
        e = model(x);
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.out_ready = 1'b0;
        chk({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = rnd48();
        chk({tag, "_v0"}, 64'(bus.out_valid), 64'd0);
        wait_valid(tag, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk({tag, "_sign"}, 64'(bus.out_sign), 64'(e[48]));
        chk({tag, "_mag"}, 64'(bus.out_mag), 64'(e[47:0]));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_retire"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    initial begin
        logic [47:0] x;
        logic [47:0] y;
        logic [48:0] e;
        logic        stable;
        int          lat;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sign", 64'(bus.out_sign), 64'd0);
        chk("rst_mag", 64'(bus.out_mag), 64'd0);
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        run("pos5", 48'h0000_0000_0005);
        run("neg5", 48'hFFFF_FFFF_FFFB);
        run("ripple", 48'hFFFF_0000_0000);
        run("mostneg", 48'h8000_0000_0000);
        run("zero", 48'h0000_0000_0000);
        run("maxpos", 48'h7FFF_FFFF_FFFF);
        for (int i = 0; i < 20; i++) run("rand", rnd48());

        // Backpressure, then back-to-back retire/accept on one edge.
        x = 48'hFEDC_BA98_7654;
        y = 48'h0123_4567_89AB;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        step();
        bus.in_valid = 1'b0;
        wait_valid("bp", lat);
        e = model(x);
        chk("bp_sign", 64'(bus.out_sign), 64'(e[48]));
        chk("bp_mag", 64'(bus.out_mag), 64'(e[47:0]));
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rnd48();
            step();
            if (!bus.out_valid || bus.in_ready || bus.out_mag !== e[47:0] ||
                bus.out_sign !== e[48]) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        bus.in_data   = y;
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_rdy", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_v0", 64'(bus.out_valid), 64'd0);
        wait_valid("b2b", lat);
        chk("b2b_lat", 64'(lat), 64'd3);
        e = model(y);
        chk("b2b_sign", 64'(bus.out_sign), 64'(e[48]));
        chk("b2b_mag", 64'(bus.out_mag), 64'(e[47:0]));

        // Reset in the middle of a conversion.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 48'hFFF0_0000_1234;
        step();
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_mag", 64'(bus.out_mag), 64'd0);
        chk("mid_rst_sign", 64'(bus.out_sign), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        run("neg1", 48'hFFFF_FFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
